instruction_fetch: RTL and testbench

- Fetch stage directly upstream of instruction decode.
- Holds the PC and issues in-order requests to an instruction memory with a grant/response handshake.
- Buffers returned words in a small queue and presents {pc, instruction} to decode with valid/ready.
- Takes PC redirects from the branch/jump path and discards stale in-flight responses.

---
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage, instruction memory, the redirect path and decode.
// The master side is the fetch stage; the slave side is its environment.
interface instruction_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_inst_ready;

  modport master (
    output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_pc,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_pc,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// In-order instruction fetch: credit-limited memory requests, a small response queue toward
// decode, and redirect handling that drops every response still in flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  instruction_fetch_if.master bus
);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          r_run;
  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_last_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_req;
  logic          w_fire;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [31:0]   w_inst;
  logic [31:0]   w_pc;
  logic [31:0]   w_target;

  // Outstanding requests plus queued words never exceed DEPTH, so a push always has room.
  assign w_credit = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req    = r_run && (w_credit < (CW+1)'(DEPTH)) && !bus.i_redirect;
  assign w_fire   = w_req && bus.i_imem_gnt;
  assign w_rsp    = bus.i_imem_rvalid && (r_inflight != '0);
  assign w_push   = w_rsp && (r_discard == '0) && !bus.i_redirect;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && bus.i_inst_ready;
  assign w_inst   = w_valid ? r_q_inst[r_rd_ptr] : NOP;
  assign w_pc     = w_valid ? r_q_pc[r_rd_ptr] : r_last_pc;
  assign w_target = bus.i_redirect_pc & ~32'h0000_0003;

  assign bus.o_imem_req   = w_req;
  assign bus.o_imem_addr  = r_pc;
  assign bus.o_inst_valid = w_valid;
  assign bus.o_inst       = w_inst;
  assign bus.o_pc         = w_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_last_pc  <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_run      <= 1'b1;
      r_last_pc  <= w_pc;
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rsp);
      if (bus.i_redirect) begin
        // Everything still outstanding after this edge belongs to the old path.
        r_pc      <= w_target;
        r_resp_pc <= w_target;
        r_discard <= r_inflight - CW'(w_rsp);
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
      end else begin
        if (w_fire)
          r_pc <= r_pc + 32'd4;
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PW'(1);
        end
        if (w_rsp && (r_discard != '0))
          r_discard <= r_discard - CW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= bus.i_imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: fixed vector table, directed redirect/reset sequences and a
// randomized run against an address-tagged memory/queue model.
module tb_instruction_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if bus();
  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  req_t        pend[$];
  logic [31:0] words[$];
  logic [31:0] fired[$];
  logic [31:0] deliv[$];
  logic [31:0] m_next = RESET_PC;
  logic [31:0] m_last = '0;
  bit          m_run = 1'b0;
  bit          m_chk = 1'b0;
  int          m_epoch = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] f_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_at(input string name, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
    if (q.size() > idx) chk(name, q[idx], exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: only %0d entries seen, expected %h at index %0d", name, q.size(), exp, idx);
    end
  endtask

  // One clock cycle: drive at negedge, sample and check, advance the model, cross the posedge.
  task automatic step(input logic rst_v, input logic gnt, input logic rv_en, input logic rdy,
                      input logic redir, input logic [31:0] rpc, input logic stray);
    logic        e_req, e_valid;
    logic [31:0] e_pc;
    req_t        r;
    rst                = rst_v;
    bus.i_imem_gnt     = gnt;
    bus.i_inst_ready   = rdy;
    bus.i_redirect     = redir;
    bus.i_redirect_pc  = rpc;
    bus.i_imem_rvalid  = stray || (rv_en && (pend.size() > 0));
    bus.i_imem_rdata   = (pend.size() > 0) ? f_word(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_req   = bus.o_imem_req;
    s_addr  = bus.o_imem_addr;
    s_valid = bus.o_inst_valid;
    s_pc    = bus.o_pc;
    s_inst  = bus.o_inst;
    e_req   = m_run && ((pend.size() + words.size()) < DEPTH) && !redir;
    e_valid = (words.size() != 0);
    e_pc    = e_valid ? words[0] : m_last;
    if (m_chk) begin
      chk("model_req", 32'(s_req), 32'(e_req));
      if (e_req) chk("model_addr", s_addr, m_next);
      chk("model_valid", 32'(s_valid), 32'(e_valid));
      chk("model_pc", s_pc, e_pc);
      chk("model_inst", s_inst, e_valid ? f_word(words[0]) : NOP);
    end
    if (!rst_v) begin
      pend.delete();
      words.delete();
      m_run  = 1'b0;
      m_next = RESET_PC;
      m_last = '0;
      m_epoch++;
    end else begin
      m_last = e_pc;
      if (s_valid && rdy) deliv.push_back(s_pc);
      if (e_valid && rdy) void'(words.pop_front());
      if (bus.i_imem_rvalid && (pend.size() > 0)) begin
        r = pend.pop_front();
        if (!redir && (r.epoch == m_epoch)) words.push_back(r.addr);
      end
      if (s_req && gnt) begin
        pend.push_back('{addr: s_addr, epoch: m_epoch});
        fired.push_back(s_addr);
        m_next = m_next + 32'd4;
      end
      if (redir) begin
        words.delete();
        m_epoch++;
        m_next = rpc & ~32'h3;
      end
      m_run = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fired.delete();
    deliv.delete();
  endtask

  vec_t vecs[17];

  initial begin
    rst = 1'b0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
    bus.i_redirect = 1'b0; bus.i_redirect_pc = '0; bus.i_inst_ready = 1'b0;
    @(negedge clk);
    do_reset();
    m_chk = 1'b1;

    // Reset state, still holding reset.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_inst", s_inst, NOP);
    chk("rst_pc", s_pc, 32'h0);

    // gnt=1, 1-cycle memory, ready=1, with a 5-cycle decode stall in rows 9..13.
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[5]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h04};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vecs[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0C};
    for (int i = 9; i < 14; i++) vecs[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[14] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[15] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    vecs[16] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h14};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 1'b1, vecs[i].rdy, 1'b0, 32'h0, 1'b0);
      chk($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].pc);
    end

    // Redirect with two requests outstanding.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    fired.delete();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    chk("redir2_req", 32'(s_req), 32'd0);
    run(10);
    chk_at("redir2_addr", fired, 0, 32'h0000_0100);
    chk_at("redir2_first_pc", deliv, 0, 32'h0000_0100);

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    run(3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    chk("redir_hs_valid", 32'(s_valid), 32'd1);
    chk_at("redir_hs_pc", deliv, 0, 32'h0);
    run(1);
    chk("redir_hs_next_valid", 32'(s_valid), 32'd0);
    chk("redir_hs_next_req", 32'(s_req), 32'd1);
    chk("redir_hs_next_addr", s_addr, 32'h0000_0200);
    run(6);
    chk_at("redir_hs_deliv", deliv, 1, 32'h0000_0200);

    // Redirect to the top of the address space wraps to zero.
    do_reset();
    run(3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    fired.delete();
    deliv.delete();
    run(8);
    chk_at("wrap_addr0", fired, 0, 32'hFFFF_FFFC);
    chk_at("wrap_addr1", fired, 1, 32'h0000_0000);
    chk_at("wrap_deliv1", deliv, 1, 32'h0000_0000);

    // Reset with a full queue, then a stray response while nothing is outstanding.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_valid", 32'(s_valid), 32'd1);
    chk("full_req", 32'(s_req), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_valid", 32'(s_valid), 32'd0);
    chk("midrst_inst", s_inst, NOP);
    chk("midrst_req", 32'(s_req), 32'd0);
    chk("midrst_pc", s_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("restart_req", 32'(s_req), 32'd1);
    chk("restart_addr", s_addr, RESET_PC);
    chk("restart_valid", 32'(s_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_gnt, r_rv, r_rdy, r_redir, r_stray;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 999) >= 3);
      r_gnt   = ($urandom_range(0, 99) < 75);
      r_rv    = ($urandom_range(0, 99) < 70);
      r_rdy   = ($urandom_range(0, 99) < 70);
      r_redir = ($urandom_range(0, 99) < 4);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_stray = (pend.size() == 0) && ($urandom_range(0, 99) < 2);
      step(r_rst, r_gnt, r_rv, r_rdy, r_redir, r_pc, r_stray);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
